// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver and its receive FIFO.
package uart_pkg;
    localparam int MIN_DIV    = 4;
    localparam int MAX_DATA_W = 9;
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRKWAIT
    } rx_state_e;
    typedef struct packed {
        logic                  brk;
        logic                  ferr;
        logic                  perr;
        logic [MAX_DATA_W-1:0] data;
    } rx_word_t;
endpackage

// File: rtl/uart_rx_fifo_param_sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered head word; a full FIFO drops pushes even when popping.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [LW-1:0]    r_bc;
    logic             r_hv;
    logic [WIDTH-1:0] r_head;
    logic             w_push, w_load, w_from_mem, w_bypass, w_wr;

    assign o_level    = LW'(r_hv) + r_bc;
    assign o_full     = o_level == LW'(DEPTH);
    assign o_valid    = r_hv;
    assign o_data     = r_head;
    assign w_push     = i_push & ~o_full;
    // the head register refills when empty or being popped; body words take priority over a bypass
    assign w_load     = ~r_hv | i_pop;
    assign w_from_mem = w_load & (r_bc != '0);
    assign w_bypass   = w_push & w_load & (r_bc == '0);
    assign w_wr       = w_push & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_bc   <= '0;
            r_hv   <= 1'b0;
            r_head <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_from_mem)
                r_rp <= r_rp + 1'b1;
            r_bc <= r_bc + LW'(w_wr) - LW'(w_from_mem);
            if (w_load) begin
                r_hv <= w_from_mem | w_bypass;
                if (w_from_mem)
                    r_head <= r_mem[r_rp];
                else if (w_bypass)
                    r_head <= i_data;
            end
        end
    end
endmodule

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: UART receiver with runtime baud divisor, framing/break detection and receive FIFO.
// Define UART_RX_PARITY_EN to enable the parity bit and cfg_par.
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic [1:0]             cfg_par,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_perr,
    output logic                   m_ferr,
    output logic                   m_brk,
    output logic                   ovr,
    input  logic                   ovr_clr,
    output logic [$clog2(DEPTH):0] level
);
    localparam int BW = $clog2(DATA_W + 1);
    logic [1:0]        r_sync;
    logic              w_rxs, w_tick, w_par_en, w_perr, w_brk, w_full, w_unused;
    rx_state_e         r_state, w_next;
    logic [DIV_W-1:0]  r_cnt, r_div, w_div;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shreg;
    logic              r_push, r_ovr;
    rx_word_t          r_word, w_head;

    assign w_rxs  = r_sync[1];
    assign w_tick = r_cnt == '0;
    assign w_div  = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

`ifdef UART_RX_PARITY_EN
    parity_e r_par;
    logic    r_pbit;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par  <= PAR_NONE;
            r_pbit <= 1'b0;
        end else begin
            if (r_state == S_IDLE && !w_rxs)
                r_par <= (cfg_par == PAR_EVEN || cfg_par == PAR_ODD) ? parity_e'(cfg_par) : PAR_NONE;
            if (r_state == S_PARITY && w_tick)
                r_pbit <= w_rxs;
        end
    end
    assign w_par_en = r_par != PAR_NONE;
    assign w_perr   = w_par_en & ((^r_shreg ^ r_pbit) != (r_par == PAR_ODD));
    assign w_brk    = ~w_rxs & ~|r_shreg & ~(w_par_en & r_pbit);
    assign w_unused = ^w_head.data;
`else
    assign w_par_en = 1'b0;
    assign w_perr   = 1'b0;
    assign w_brk    = ~w_rxs & ~|r_shreg;
    assign w_unused = ^{w_head.data, cfg_par};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_rxs ? S_IDLE : S_START;
            S_START:   w_next = !w_tick ? S_START : (w_rxs ? S_IDLE : S_DATA);
            S_DATA:    w_next = (w_tick && r_bit == BW'(DATA_W - 1)) ? (w_par_en ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY:  w_next = w_tick ? S_STOP : S_PARITY;
            S_STOP:    w_next = !w_tick ? S_STOP : (w_rxs ? S_IDLE : S_BRKWAIT);
            S_BRKWAIT: w_next = w_rxs ? S_IDLE : S_BRKWAIT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= DIV_W'(MIN_DIV);
            r_bit   <= '0;
            r_shreg <= '0;
            r_push  <= 1'b0;
            r_word  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_next;
            r_push  <= 1'b0;
            r_cnt   <= w_tick ? r_cnt : r_cnt - 1'b1;
            r_ovr   <= (r_push & w_full) ? 1'b1 : (ovr_clr ? 1'b0 : r_ovr);
            case (r_state)
                S_IDLE: if (!w_rxs) begin
                    r_div <= w_div;
                    r_cnt <= w_div >> 1;
                end
                S_START: if (w_tick) begin
                    r_cnt <= r_div - 1'b1;
                    r_bit <= '0;
                end
                S_DATA: if (w_tick) begin
                    r_shreg <= {w_rxs, r_shreg[DATA_W-1:1]};
                    r_bit   <= r_bit + 1'b1;
                    r_cnt   <= r_div - 1'b1;
                end
                S_PARITY: if (w_tick)
                    r_cnt <= r_div - 1'b1;
                S_STOP: if (w_tick) begin
                    r_push <= 1'b1;
                    r_word <= {w_brk, ~w_rxs, w_perr, MAX_DATA_W'(r_shreg)};
                end
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH($bits(rx_word_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_data  (r_word),
        .i_pop   (m_ready),
        .o_data  (w_head),
        .o_valid (m_valid),
        .o_full  (w_full),
        .o_level (level)
    );

    assign m_data = w_head.data[DATA_W-1:0];
    assign m_perr = w_head.perr;
    assign m_ferr = w_head.ferr;
    assign m_brk  = w_head.brk;
    assign ovr    = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: drives serial frames on rx and checks delivered words against a frame-level model.
module tb_uart_rx_fifo_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] cfg_div = 16'd16;
    logic [1:0]  cfg_par = 2'd0;
    logic        m_ready = 1'b1;
    logic        ovr_clr = 1'b0;
    logic        m_valid, m_perr, m_ferr, m_brk, ovr;
    logic [7:0]  m_data;
    logic [2:0]  level;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    logic [10:0] got_q[$];

    uart_rx_fifo_param #(.DATA_W(8), .DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .cfg_div(cfg_div), .cfg_par(cfg_par),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr),
        .m_ferr(m_ferr), .m_brk(m_brk), .ovr(ovr), .ovr_clr(ovr_clr), .level(level)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && m_valid && m_ready)
            got_q.push_back({m_brk, m_ferr, m_perr, m_data});

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // word = {brk, ferr, perr, data}; mode 0 none, 1 even, 2 odd
    function automatic logic [10:0] model(input logic [7:0] d, input bit pbit, input bit stop, input int mode);
        int  ones = $countones(d) + (pbit ? 1 : 0);
        bit  perr = (mode == 1) ? (ones % 2 == 1) : (mode == 2) ? (ones % 2 == 0) : 1'b0;
        bit  ferr = !stop;
        bit  brk  = ferr && d == 8'd0 && (mode == 0 || !pbit);
        return {brk, ferr, perr, d};
    endfunction

    function automatic bit good_par(input logic [7:0] d, input int mode);
        return (mode == 2) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
    endfunction

    function automatic int eff_mode(input logic [1:0] p);
`ifdef UART_RX_PARITY_EN
        return (p == 2'd1 || p == 2'd2) ? int'(p) : 0;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit b, input int n);
        rx = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop, input int n, input int mode);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++)
            send_bit(d[i], n);
        if (mode != 0)
            send_bit(pbit, n);
        send_bit(stop, n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        tot_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", m_valid); else pass_cnt++;
        tot_cnt++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
        tot_cnt++; if (ovr !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", ovr); else pass_cnt++;
        tot_cnt++; if ({m_brk, m_ferr, m_perr, m_data} !== 11'd0) $display("FAIL reset_word got=%h exp=0", {m_brk, m_ferr, m_perr, m_data}); else pass_cnt++;
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic;
        logic [7:0] d = 8'hA5;
        got_q.delete();
        cfg_div = 16'd16;
        cfg_par = 2'd0;
        m_ready = 1'b0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++)
            send_bit(d[i], 16);
        rx = 1'b1;
        // mid-stop is sampled 12 edges into the stop bit (2 sync + 1 detect + 9 half-bit), word visible 1 edge later
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 12) begin
                tot_cnt++; if (m_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", m_valid); else pass_cnt++;
            end
            if (k == 13) begin
                tot_cnt++; if (m_valid !== 1'b1) $display("FAIL basic_latency_valid got=%b exp=1", m_valid); else pass_cnt++;
            end
        end
        tot_cnt++; if ({m_brk, m_ferr, m_perr, m_data} !== model(d, 1'b0, 1'b1, 0)) $display("FAIL basic_word got=%h exp=%h", {m_brk, m_ferr, m_perr, m_data}, model(d, 1'b0, 1'b1, 0)); else pass_cnt++;
        tot_cnt++; if (level !== 3'd1) $display("FAIL basic_level got=%0d exp=1", level); else pass_cnt++;
        m_ready = 1'b1;
        tick(3);
        tot_cnt++; if (level !== 3'd0) $display("FAIL basic_drain_level got=%0d exp=0", level); else pass_cnt++;
        tot_cnt++; if (got_q.size() != 1) $display("FAIL basic_count got=%0d exp=1", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_parity;
        logic [10:0] exp_q[$];
        got_q.delete();
        cfg_div = 16'd16;
        cfg_par = 2'd1;
        send_frame(8'h03, 1'b0, 1'b1, 16, eff_mode(cfg_par));
        exp_q.push_back(model(8'h03, 1'b0, 1'b1, eff_mode(cfg_par)));
        send_frame(8'h01, 1'b0, 1'b1, 16, eff_mode(cfg_par));
        exp_q.push_back(model(8'h01, 1'b0, 1'b1, eff_mode(cfg_par)));
        tick(40);
        tot_cnt++; if (got_q.size() != 2) $display("FAIL parity_count got=%0d exp=2", got_q.size()); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tot_cnt++;
            if (i >= got_q.size()) $display("FAIL parity_word%0d got=none exp=%h", i, exp_q[i]);
            else if (got_q[i] !== exp_q[i]) $display("FAIL parity_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        cfg_par = 2'd0;
    endtask

    task automatic test_glitch;
        got_q.delete();
        cfg_div = 16'd16;
        send_bit(1'b0, 6);
        send_bit(1'b1, 40);
        tot_cnt++; if (got_q.size() != 0 || level !== 3'd0) $display("FAIL glitch_noword got=%0d/%0d exp=0/0", got_q.size(), level); else pass_cnt++;
        send_frame(8'h96, 1'b0, 1'b1, 16, 0);
        tick(40);
        tot_cnt++;
        if (got_q.size() != 1) $display("FAIL glitch_next_count got=%0d exp=1", got_q.size());
        else if (got_q[0] !== model(8'h96, 1'b0, 1'b1, 0)) $display("FAIL glitch_next_word got=%h exp=%h", got_q[0], model(8'h96, 1'b0, 1'b1, 0));
        else pass_cnt++;
    endtask

    task automatic test_break;
        logic [10:0] exp_q[$];
        got_q.delete();
        cfg_div = 16'd16;
        send_frame(8'h5A, 1'b0, 1'b0, 16, 0);
        exp_q.push_back(model(8'h5A, 1'b0, 1'b0, 0));
        send_bit(1'b1, 32);
        send_bit(1'b0, 40 * 16);
        exp_q.push_back(model(8'h00, 1'b0, 1'b0, 0));
        tot_cnt++; if (got_q.size() != 2) $display("FAIL break_hold_count got=%0d exp=2", got_q.size()); else pass_cnt++;
        send_bit(1'b1, 32);
        send_frame(8'h33, 1'b0, 1'b1, 16, 0);
        exp_q.push_back(model(8'h33, 1'b0, 1'b1, 0));
        tick(40);
        tot_cnt++; if (got_q.size() != 3) $display("FAIL break_count got=%0d exp=3", got_q.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tot_cnt++;
            if (i >= got_q.size()) $display("FAIL break_word%0d got=none exp=%h", i, exp_q[i]);
            else if (got_q[i] !== exp_q[i]) $display("FAIL break_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun;
        got_q.delete();
        cfg_div = 16'd16;
        m_ready = 1'b0;
        tick(1);
        for (int v = 1; v <= 6; v++)
            send_frame(8'(v), 1'b0, 1'b1, 16, 0);
        tick(40);
        tot_cnt++; if (level !== 3'd4) $display("FAIL ovr_level got=%0d exp=4", level); else pass_cnt++;
        tot_cnt++; if (ovr !== 1'b1) $display("FAIL ovr_set got=%b exp=1", ovr); else pass_cnt++;
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        tick(1);
        tot_cnt++; if (ovr !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", ovr); else pass_cnt++;
        m_ready = 1'b1;
        tick(10);
        tot_cnt++; if (got_q.size() != 4 || level !== 3'd0) $display("FAIL ovr_drain got=%0d/%0d exp=4/0", got_q.size(), level); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++;
            if (i >= got_q.size()) $display("FAIL ovr_word%0d got=none exp=%h", i, model(8'(i + 1), 1'b0, 1'b1, 0));
            else if (got_q[i] !== model(8'(i + 1), 1'b0, 1'b1, 0)) $display("FAIL ovr_word%0d got=%h exp=%h", i, got_q[i], model(8'(i + 1), 1'b0, 1'b1, 0));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        cfg_div = 16'd16;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 8);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        send_frame(8'h3C, 1'b0, 1'b1, 16, 0);
        tick(40);
        tot_cnt++;
        if (got_q.size() != 1) $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
        else if (got_q[0] !== model(8'h3C, 1'b0, 1'b1, 0)) $display("FAIL rstmid_word got=%h exp=%h", got_q[0], model(8'h3C, 1'b0, 1'b1, 0));
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [10:0] exp_q[$];
        got_q.delete();
        m_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] d;
            int  div, eff, mode;
            bit  pbit, stop;
            d       = ($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom);
            div     = $urandom_range(20, 0);
            eff     = (div < 4) ? 4 : div;
            cfg_div = 16'(div);
            cfg_par = 2'($urandom_range(3, 0));
            mode    = eff_mode(cfg_par);
            pbit    = good_par(d, mode) ^ ($urandom_range(3, 0) == 0);
            stop    = $urandom_range(5, 0) != 0;
            send_frame(d, pbit, stop, eff, mode);
            exp_q.push_back(model(d, pbit, stop, mode));
            if (!stop || $urandom_range(1, 0) == 1)
                send_bit(1'b1, eff);
        end
        tick(100);
        tot_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            tot_cnt++;
            if (i >= got_q.size()) $display("FAIL rand_word%0d got=none exp=%h", i, exp_q[i]);
            else if (got_q[i] !== exp_q[i]) $display("FAIL rand_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            else pass_cnt++;
        end
        cfg_par = 2'd0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_break;
        test_overrun;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
